seq_chk_monitor: RTL
====================

# seq_chk_monitor

Synthesizable multi-channel protocol checker for the three-step handshake "a, then b after GAP_AB cycles, then c after GAP_BC cycles". Each channel runs its own non-overlapping check thread. On completion, the block updates per-channel pass and fail counters and posts a timestamped completion event on a valid/ready output. It sits beside the bus or handshake logic it watches and gives on-silicon pass/fail reporting in place of simulation-only completion callbacks.

## Interface
- CH, 4: channel count, 1..16
- GAP_AB, 1: cycles from sampling a to checking b, 1..255
- GAP_BC, 1: cycles from checking b to checking c, 1..255
- TS_W, 16: timestamp width
- CNT_W, 8: pass/fail counter width per channel
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  global enable; 0 aborts all threads and holds channels idle
- clr_cnt  in  1  synchronous clear of pass_cnt, fail_cnt and ovf
- a, b, c  in  CH each  per-channel step signals, sampled at posedge
- evt_ready  in  1  consumer accepts the event
- evt_valid  out  1  event slot occupied
- evt_ch  out  max(1,$clog2(CH))  channel of the event
- evt_pass  out  1  1 = pass, 0 = fail
- evt_ts  out  TS_W  timestamp of the check edge
- pass_cnt, fail_cnt  out  CH*CNT_W each  per-channel saturating counters; channel i is at [i*CNT_W +: CNT_W]
- ovf  out  CH  sticky; set when an event is dropped
- busy  out  CH  channel is not in IDLE

## Operation
- ts_cnt: free-running TS_W-bit counter. It is 0 at the first edge after reset release, increments every edge and wraps modulo 2^TS_W.
- Per-channel FSM has three states:
  - IDLE: a=1 at an edge loads the delay counter with GAP_AB and moves to WAIT_B.
  - WAIT_B: decrements each edge. At the edge where it reaches 0 (the b-check edge), b=1 moves to WAIT_C with the counter reloaded to GAP_BC. b=0 returns to IDLE; the attempt is vacuous, so no event and no counter change.
  - WAIT_C: at the c-check edge, c=1 is a pass and c=0 is a fail. Both return to IDLE.
- Non-overlapping threads: a is ignored outside IDLE, including at the c-check edge itself. Values of b and c outside their check edges are ignored.
- At the c-check edge the block:
  - increments pass_cnt[ch] or fail_cnt[ch], saturating at all-ones;
  - sets pend[ch] and captures pend_pass[ch] and pend_ts[ch] = ts_cnt at that edge.
- Output slot loads when evt_valid=0 or evt_ready=1. It takes the lowest-index set pend bit, and that bit clears on the same edge.
- A newly completing channel whose pend bit is still set and is not being moved that edge sets ovf[ch]. The new event is dropped; the counters still update.
- If pend[ch] moves to the slot on the same edge ch completes again, the new event takes pend[ch] and ovf is not set.
- clr_cnt zeroes counters and ovf. It has priority over a same-edge increment. It does not affect FSMs, pend or the event slot.
- en=0 forces all FSMs to IDLE with no event and no counter change. Pending and slot events still drain; ts_cnt keeps running.

## Timing
- Reset values: all FSMs IDLE; ts_cnt, counters, ovf, pend and busy are 0; evt_valid, evt_ch, evt_pass and evt_ts are 0.
- a sampled at edge k: b checked at edge k+GAP_AB, c checked at k+GAP_AB+GAP_BC.
- Event latency: pend sets at check edge E. evt_valid rises after edge E+1 at the earliest.
- Handshake: a transfer occurs at an edge with evt_valid=1 and evt_ready=1. evt_ch, evt_pass and evt_ts are stable while evt_valid=1 and evt_ready=0. With evt_ready held at 1, back-to-back events go out one per cycle.
- busy[ch] is high from the edge after a is accepted through the check edge; it is low after the check edge.
- Reset assertion mid-thread clears everything immediately. The aborted attempt is not reported.

## Test plan
- CH=4, gaps 1/1; ch0: a@edge2, b@3, c@4 -> evt_valid rises after edge5; evt_ch=0, evt_pass=1, evt_ts=4; pass_cnt[0]=1.
- Same stimulus with c=0@4 -> evt_pass=0, evt_ts=4, fail_cnt[0]=1. With b=0@3 instead -> no event and both counters stay 0.
- GAP_AB=3, GAP_BC=2; a@10 and a@11 (second ignored), b@13, c@15 -> exactly one pass event with ts=15 and busy[0] high over edges 11..15.
- ch0..ch3 all pass at edge 20 with evt_ready=0 until edge 30 -> events emerge in order ch 0,1,2,3, one per cycle after ready rises. A second completion on ch3 at edge 24 sets ovf[3]=1.
- CNT_W=2: 5 passes on ch1 -> pass_cnt[1]=3 (saturated). clr_cnt on the edge of a 6th pass -> pass_cnt[1]=0.
- rst_n low for one cycle during WAIT_C, and separately en=0 mid-thread -> no event; all outputs at reset or idle values; the next full sequence passes normally.

Source files
------------

// File: rtl/seq_chk_monitor.sv
// seq_chk_monitor: multi-channel checker for the handshake "a, then b after
// GAP_AB cycles, then c after GAP_BC cycles". Each channel keeps saturating
// pass/fail counters; completions are queued per channel and drained through a
// single timestamped valid/ready event slot.

// Per-channel check thread plus its pass/fail counters.
module seq_chk_ch #(
   parameter int GAP_AB = 1,
   parameter int GAP_BC = 1,
   parameter int CNT_W  = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             a_i,
   input  logic             b_i,
   input  logic             c_i,
   output logic             done_o,
   output logic             pass_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] pass_cnt_o,
   output logic [CNT_W-1:0] fail_cnt_o
);

   typedef enum logic [1:0] {IDLE, WAIT_B, WAIT_C} state_e;

   localparam logic [7:0] GAB = 8'(GAP_AB);
   localparam logic [7:0] GBC = 8'(GAP_BC);

   state_e           state_q, state_d;
   logic [7:0]       dly_q, dly_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;

   // State and delay counter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         dly_q   <= '0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
      end
   end

   // Thread sequencing; the check edge is the one where the delay hits 0,
   // i.e. where the registered value is still 1.
   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      done_o  = 1'b0;
      pass_o  = 1'b0;
      if (!en_i) begin
         state_d = IDLE;
         dly_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (a_i) begin
                  state_d = WAIT_B;
                  dly_d   = GAB;
               end
            end
            WAIT_B: begin
               if (dly_q == 8'd1) begin
                  if (b_i) begin
                     state_d = WAIT_C;
                     dly_d   = GBC;
                  end else begin
                     // vacuous attempt: silently back to idle
                     state_d = IDLE;
                     dly_d   = '0;
                  end
               end else begin
                  dly_d = dly_q - 8'd1;
               end
            end
            WAIT_C: begin
               if (dly_q == 8'd1) begin
                  done_o  = 1'b1;
                  pass_o  = c_i;
                  state_d = IDLE;
                  dly_d   = '0;
               end else begin
                  dly_d = dly_q - 8'd1;
               end
            end
            default: begin
               state_d = IDLE;
               dly_d   = '0;
            end
         endcase
      end
   end

   // Saturating counters; clear wins over a same-edge increment
   always_comb begin
      pcnt_d = pcnt_q;
      fcnt_d = fcnt_q;
      if (clr_i) begin
         pcnt_d = '0;
         fcnt_d = '0;
      end else if (done_o) begin
         if (pass_o) begin
            if (pcnt_q != '1) pcnt_d = pcnt_q + 1'b1;
         end else begin
            if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pcnt_q <= '0;
         fcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign busy_o     = (state_q != IDLE);
   assign pass_cnt_o = pcnt_q;
   assign fail_cnt_o = fcnt_q;

endmodule

// Top: channel array, pending-event capture, priority drain into the slot.
module seq_chk_monitor #(
   parameter int CH     = 4,
   parameter int GAP_AB = 1,
   parameter int GAP_BC = 1,
   parameter int TS_W   = 16,
   parameter int CNT_W  = 8
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 en_i,
   input  logic                                 clr_cnt_i,
   input  logic [CH-1:0]                        a_i,
   input  logic [CH-1:0]                        b_i,
   input  logic [CH-1:0]                        c_i,
   input  logic                                 evt_ready_i,
   output logic                                 evt_valid_o,
   output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] evt_ch_o,
   output logic                                 evt_pass_o,
   output logic [TS_W-1:0]                      evt_ts_o,
   output logic [CH*CNT_W-1:0]                  pass_cnt_o,
   output logic [CH*CNT_W-1:0]                  fail_cnt_o,
   output logic [CH-1:0]                        ovf_o,
   output logic [CH-1:0]                        busy_o
);

   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

   logic [CH-1:0]             done, pass;
   logic [CH-1:0][CNT_W-1:0]  pcnt, fcnt;

   logic [TS_W-1:0]           ts_q, ts_d;
   logic [CH-1:0]             pend_q, pend_d;
   logic [CH-1:0]             pend_pass_q, pend_pass_d;
   logic [CH-1:0][TS_W-1:0]   pend_ts_q, pend_ts_d;
   logic [CH-1:0]             ovf_q, ovf_d;

   logic                      evt_valid_q, evt_valid_d;
   logic [CHW-1:0]            evt_ch_q, evt_ch_d;
   logic                      evt_pass_q, evt_pass_d;
   logic [TS_W-1:0]           evt_ts_q, evt_ts_d;

   logic                      load, found;
   logic [CH-1:0]             move;
   logic [CHW-1:0]            sel_ch;
   logic                      sel_pass;
   logic [TS_W-1:0]           sel_ts;

   for (genvar g = 0; g < CH; g++) begin : g_ch
      seq_chk_ch #(
         .GAP_AB (GAP_AB),
         .GAP_BC (GAP_BC),
         .CNT_W  (CNT_W)
      ) u_ch (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .en_i       (en_i),
         .clr_i      (clr_cnt_i),
         .a_i        (a_i[g]),
         .b_i        (b_i[g]),
         .c_i        (c_i[g]),
         .done_o     (done[g]),
         .pass_o     (pass[g]),
         .busy_o     (busy_o[g]),
         .pass_cnt_o (pcnt[g]),
         .fail_cnt_o (fcnt[g])
      );
   end

   // Slot can take a new event when empty or being consumed this edge
   assign load = !evt_valid_q || evt_ready_i;
   assign ts_d = ts_q + 1'b1;

   // Lowest-index pending channel wins the slot
   always_comb begin
      found    = 1'b0;
      move     = '0;
      sel_ch   = '0;
      sel_pass = 1'b0;
      sel_ts   = '0;
      for (int i = 0; i < CH; i++) begin
         if (pend_q[i] && !found) begin
            found    = 1'b1;
            move[i]  = load;
            sel_ch   = CHW'(i);
            sel_pass = pend_pass_q[i];
            sel_ts   = pend_ts_q[i];
         end
      end
   end

   // Pending capture; a completion whose previous event is still stuck drops
   // the new one and flags overflow, unless that old event leaves this edge.
   always_comb begin
      pend_d      = pend_q;
      pend_pass_d = pend_pass_q;
      pend_ts_d   = pend_ts_q;
      ovf_d       = ovf_q;
      for (int i = 0; i < CH; i++) begin
         if (move[i]) pend_d[i] = 1'b0;
         if (done[i]) begin
            if (pend_q[i] && !move[i]) begin
               ovf_d[i] = 1'b1;
            end else begin
               pend_d[i]      = 1'b1;
               pend_pass_d[i] = pass[i];
               pend_ts_d[i]   = ts_q;
            end
         end
      end
      if (clr_cnt_i) ovf_d = '0;
   end

   // Output slot: fields only change on a load, so they hold under backpressure
   always_comb begin
      evt_valid_d = evt_valid_q;
      evt_ch_d    = evt_ch_q;
      evt_pass_d  = evt_pass_q;
      evt_ts_d    = evt_ts_q;
      if (load) begin
         evt_valid_d = found;
         if (found) begin
            evt_ch_d   = sel_ch;
            evt_pass_d = sel_pass;
            evt_ts_d   = sel_ts;
         end
      end
   end

   // Timestamp, pending and slot registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ts_q        <= '0;
         pend_q      <= '0;
         pend_pass_q <= '0;
         pend_ts_q   <= '0;
         ovf_q       <= '0;
         evt_valid_q <= 1'b0;
         evt_ch_q    <= '0;
         evt_pass_q  <= 1'b0;
         evt_ts_q    <= '0;
      end else begin
         ts_q        <= ts_d;
         pend_q      <= pend_d;
         pend_pass_q <= pend_pass_d;
         pend_ts_q   <= pend_ts_d;
         ovf_q       <= ovf_d;
         evt_valid_q <= evt_valid_d;
         evt_ch_q    <= evt_ch_d;
         evt_pass_q  <= evt_pass_d;
         evt_ts_q    <= evt_ts_d;
      end
   end

   assign evt_valid_o = evt_valid_q;
   assign evt_ch_o    = evt_ch_q;
   assign evt_pass_o  = evt_pass_q;
   assign evt_ts_o    = evt_ts_q;
   assign pass_cnt_o  = pcnt;
   assign fail_cnt_o  = fcnt;
   assign ovf_o       = ovf_q;

endmodule
